// File: rtl/imm_packer.sv
// Immediate packer: range-checks a signed value against its op class field,
// truncates it into a 24-bit immediate and queues the result in a small FIFO.
module imm_packer #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic [31:0]      value_in,
    input  logic [1:0]       op_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic [23:0]      imm24_out,
    output logic             fit_out,
    output logic [1:0]       op_out,
    output logic             valid_out,
    input  logic             ready_in,
    output logic [CNT_W-1:0] misfit_cnt_out,
    input  logic             cnt_clr_in
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0]    DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0]    CNT_ONE = CW'(1'b1);
    localparam logic [AW-1:0]    PTR_ONE = AW'(1'b1);
    localparam logic [CNT_W-1:0] MIS_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] MIS_ONE = CNT_W'(1'b1);

    typedef struct packed {
        logic [1:0]  op;
        logic        fit;
        logic [23:0] imm;
    } entry_t;

    // A field fits when every bit above its sign bit repeats that sign bit.
    function automatic entry_t pack_entry(input logic [31:0] v, input logic [1:0] op);
        entry_t e;
        e.op  = op;
        e.fit = 1'b0;
        e.imm = 24'h000000;
        case (op)
            2'b00: begin
                e.fit = (&v[31:7]) | ~(|v[31:7]);
                e.imm = {16'h0000, v[7:0]};
            end
            2'b01: begin
                e.fit = (&v[31:11]) | ~(|v[31:11]);
                e.imm = {12'h000, v[11:0]};
            end
            2'b10: begin
                e.fit = (&v[31:23]) | ~(|v[31:23]);
                e.imm = v[23:0];
            end
            default: begin
                e.fit = 1'b0;
                e.imm = 24'h000000;
            end
        endcase
        return e;
    endfunction

    entry_t            mem_r [DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [CW-1:0]     count_r;
    logic [CW-1:0]     count_next_s;
    logic              ready_r;
    logic              valid_r;
    logic [CNT_W-1:0]  misfit_r;
    logic              push_s;
    logic              pop_s;
    entry_t            head_s;

    assign push_s = valid_in & ready_r;
    assign pop_s  = valid_r & ready_in;
    assign head_s = mem_r[rd_ptr_r];

    // Next occupancy; ready blocks a push when full, so a full+pop cycle just drains.
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_ONE;
            2'b01:   count_next_s = count_r - CNT_ONE;
            default: count_next_s = count_r;
        endcase
    end

    // FIFO storage, pointers and the registered handshake flags.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            ready_r  <= 1'b1;
            valid_r  <= 1'b0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= pack_entry(value_in, op_in);
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_next_s;
            ready_r <= (count_next_s < DEPTH_C);
            valid_r <= (count_next_s != '0);
        end
    end

    // Saturating misfit counter; a clear wins over a same-cycle increment.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            misfit_r <= '0;
        end else if (cnt_clr_in) begin
            misfit_r <= '0;
        end else if (pop_s && !head_s.fit && (misfit_r != MIS_MAX)) begin
            misfit_r <= misfit_r + MIS_ONE;
        end else begin
            misfit_r <= misfit_r;
        end
    end

    assign ready_out      = ready_r;
    assign valid_out      = valid_r;
    assign imm24_out      = head_s.imm;
    assign fit_out        = head_s.fit;
    assign op_out         = head_s.op;
    assign misfit_cnt_out = misfit_r;

endmodule

// File: tb/tb_imm_packer.sv
// Randomized self-checking bench for imm_packer against a transaction-level
// queue model that derives fit/packing from signed ranges and modular arithmetic.
module tb_imm_packer;

    localparam int DEPTH = 2;
    localparam int CNT_W = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic [31:0]      value;
    logic [1:0]       op;
    logic             vin;
    logic             ready_out;
    logic [23:0]      imm24_out;
    logic             fit_out;
    logic [1:0]       op_out;
    logic             valid_out;
    logic             rin;
    logic [CNT_W-1:0] misfit_cnt_out;
    logic             clr;

    typedef struct {
        logic [31:0] value;
        logic [1:0]  op;
    } req_t;

    req_t q[$];
    int   cnt_m;
    int   total;
    int   bad;

    imm_packer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_in         (clk),
        .rst_n_in       (rst_n),
        .value_in       (value),
        .op_in          (op),
        .valid_in       (vin),
        .ready_out      (ready_out),
        .imm24_out      (imm24_out),
        .fit_out        (fit_out),
        .op_out         (op_out),
        .valid_out      (valid_out),
        .ready_in       (rin),
        .misfit_cnt_out (misfit_cnt_out),
        .cnt_clr_in     (clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int field_w(input logic [1:0] o);
        case (o)
            2'b00:   return 8;
            2'b01:   return 12;
            2'b10:   return 24;
            default: return 0;
        endcase
    endfunction

    // Field value is v mod 2^w; it fits when v lies in [-2^(w-1), 2^(w-1)).
    function automatic void ref_pack(input logic [31:0] v, input logic [1:0] o,
                                     output logic [23:0] imm, output logic fit);
        longint sv;
        longint m;
        int     w;
        w  = field_w(o);
        sv = longint'($signed(v));
        if (w == 0) begin
            imm = 24'h0;
            fit = 1'b0;
        end else begin
            m   = longint'(1) << w;
            imm = 24'(((sv % m) + m) % m);
            fit = (sv >= -(m / 2)) && (sv < (m / 2));
        end
    endfunction

    function automatic logic [31:0] sext(input logic [23:0] imm, input logic [1:0] o);
        longint m;
        longint x;
        m = longint'(1) << field_w(o);
        x = longint'(imm) % m;
        if (x >= m / 2) x = x - m;
        return 32'(x);
    endfunction

    // One clock cycle, entered and left at a falling edge.
    task automatic cycle(input logic v_in, input logic [31:0] val, input logic [1:0] o,
                         input logic r_in, input logic c_in);
        logic [23:0] e_imm;
        logic        e_fit;
        logic        push;
        logic        pop;
        req_t        r;
        e_fit = 1'b0;
        check("valid_out", valid_out, q.size() != 0);
        check("ready_out", ready_out, q.size() < DEPTH);
        check("misfit_cnt", misfit_cnt_out, cnt_m);
        if (q.size() != 0) begin
            ref_pack(q[0].value, q[0].op, e_imm, e_fit);
            check("imm24", imm24_out, e_imm);
            check("fit", fit_out, e_fit);
            check("op_echo", op_out, q[0].op);
        end
        vin = v_in; value = val; op = o; rin = r_in; clr = c_in;
        push = v_in && (q.size() < DEPTH);
        pop  = r_in && (q.size() != 0);
        if (pop) begin
            if (e_fit) check("roundtrip", sext(imm24_out, op_out), q[0].value);
            void'(q.pop_front());
        end
        if (c_in) cnt_m = 0;
        else if (pop && !e_fit && cnt_m < CNT_MAX) cnt_m++;
        if (push) begin
            r.value = val;
            r.op    = o;
            q.push_back(r);
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic r_in);
        cycle(1'b0, 32'h0, 2'b00, r_in, 1'b0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        vin = 1'b0; rin = 1'b0; clr = 1'b0;
        #1;
        check("rst_valid", valid_out, 1'b0);
        check("rst_ready", ready_out, 1'b1);
        check("rst_misfit", misfit_cnt_out, 32'h0);
        check("rst_imm", imm24_out, 32'h0);
        check("rst_fit", fit_out, 1'b0);
        check("rst_op", op_out, 32'h0);
        q.delete();
        cnt_m = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] rand_val();
        int r;
        r = $urandom;
        return 32'(r >>> $urandom_range(0, 31));
    endfunction

    logic [31:0] dir_v [7];
    logic [1:0]  dir_o [7];

    initial begin
        total = 0; bad = 0; cnt_m = 0;
        rst_n = 1'b0; value = 32'h0; op = 2'b00; vin = 1'b0; rin = 1'b0; clr = 1'b0;
        apply_reset();

        // Directed fit/packing boundaries, streamed back to back.
        dir_v = '{32'hFFFFFFFB, 32'h00000080, 32'h000007FF, 32'hFFFFF800,
                  32'h00800000, 32'hFF800000, 32'h12345678};
        dir_o = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b11};
        for (int i = 0; i < 7; i++) cycle(1'b1, dir_v[i], dir_o[i], 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Backpressure: third push refused, head held, then full+pop.
        for (int i = 0; i < 3; i++) cycle(1'b1, rand_val(), 2'($urandom_range(0, 3)), 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) idle(1'b0);
        cycle(1'b1, rand_val(), 2'b01, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Streaming at full rate.
        for (int i = 0; i < 16; i++) cycle(1'b1, rand_val(), 2'($urandom_range(0, 2)), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Random handshake mix.
        for (int i = 0; i < 300; i++)
            cycle(1'($urandom_range(0, 1)), rand_val(), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 40) == 0));
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Counter saturation, then clear coincident with a misfit pop.
        cycle(1'b0, 32'h0, 2'b00, 1'b1, 1'b1);
        for (int i = 0; i < 262; i++) cycle(1'b1, $urandom, 2'b11, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) idle(1'b1);
        check("sat_value", misfit_cnt_out, CNT_MAX);
        cycle(1'b1, 32'h00000100, 2'b00, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 2'b00, 1'b1, 1'b1);
        idle(1'b1);
        check("clr_wins", misfit_cnt_out, 32'h0);

        // Reset with two entries buffered.
        cycle(1'b1, 32'h00000005, 2'b00, 1'b0, 1'b0);
        cycle(1'b1, 32'h00001000, 2'b01, 1'b0, 1'b0);
        idle(1'b0);
        apply_reset();
        for (int i = 0; i < 2; i++) idle(1'b1);
        cycle(1'b1, 32'hFFFFFF80, 2'b00, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) idle(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
